// File: rtl/multdiv_pkg.sv
// Shared state encoding and iteration counts for the sequential multiply/divide unit.
// MULTDIV_BOOTH4_EN halves the multiply iteration count (radix-4 Booth).
package multdiv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MULT,
      DIV,
      FIN,
      DONE
   } state_t;

`ifdef MULTDIV_BOOTH4_EN
   localparam int MULT_ITERS = 16;
`else
   localparam int MULT_ITERS = 32;
`endif
   localparam int          DIV_ITERS = 32;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/adder_32bit_cas.sv
// 32-bit carry-select adder: 16-bit low half, upper half precomputed for both carries.
// Combinational, no flow control.
module adder_32bit_cas (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);

   logic [16:0] lo;
   logic [16:0] hi0;
   logic [16:0] hi1;

   assign lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'b0, cin};
   assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
   assign hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

   assign sum  = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
   assign cout = lo[16] ? hi1[16] : hi0[16];

endmodule

// File: rtl/multdiv_addsub.sv
// Add/subtract step for the multiply/divide datapath; subtract is a + ~b + 1.
// Combinational, no flow control.
module multdiv_addsub (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic [31:0] sum,
   output logic        cout
);

   logic [31:0] b_eff;

   assign b_eff = sub ? ~b : b;

   adder_32bit_cas u_adder (
      .a    (a),
      .b    (b_eff),
      .cin  (sub),
      .sum  (sum),
      .cout (cout)
   );

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply/divide; MULTDIV_BOOTH4_EN selects radix-4 Booth multiply.
// Latency 33 edges to RDY (17 for radix-4 multiply, 2 for divide-by-zero); starts ignored while busy.
module multdiv_seq
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic [WIDTH-1:0] mcand;
   logic             q_1;
   logic             op_div;
   logic             neg_res;
   logic             div_zero;
   logic             div_ovf;

   logic             start;
   logic             accept;
   logic             cnt_last;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;

   logic [WIDTH-1:0] as_a;
   logic [WIDTH-1:0] as_b;
   logic             as_sub;
   logic [WIDTH-1:0] as_sum;
   logic             as_cout;

   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] mq_nxt;
   logic             q_1_nxt;

`ifdef MULTDIV_BOOTH4_EN
   logic [WIDTH+1:0] b34;
   logic             sub4;
   logic [1:0]       hi;
`endif

   assign start    = ctrl_MULT | ctrl_DIV;
   assign accept   = start && (state == IDLE || state == DONE);
   assign cnt_last = (state == MULT) ? (cnt == CNT_W'(MULT_ITERS - 1))
                                     : (cnt == CNT_W'(DIV_ITERS - 1));
   assign mag_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign mag_b    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      busy           = 1'b0;
      data_resultRDY = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = ctrl_MULT ? MULT : DIV;
         MULT: begin
            busy = 1'b1;
            if (cnt_last) state_nxt = FIN;
         end
         DIV: begin
            busy = 1'b1;
            if (div_zero || cnt_last) state_nxt = FIN;
         end
         FIN: begin
            busy      = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            data_resultRDY = 1'b1;
            state_nxt      = start ? (ctrl_MULT ? MULT : DIV) : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Adder operand select: Booth step, restoring trial subtract, or final quotient negate.
   always_comb begin
      as_a   = acc;
      as_b   = '0;
      as_sub = 1'b0;
`ifdef MULTDIV_BOOTH4_EN
      b34  = '0;
      sub4 = 1'b0;
`endif
      case (state)
         MULT: begin
`ifdef MULTDIV_BOOTH4_EN
            case ({mq[1:0], q_1})
               3'b001, 3'b010: b34 = {{2{mcand[WIDTH-1]}}, mcand};
               3'b011:         b34 = {mcand[WIDTH-1], mcand, 1'b0};
               3'b100: begin
                  b34  = {mcand[WIDTH-1], mcand, 1'b0};
                  sub4 = 1'b1;
               end
               3'b101, 3'b110: begin
                  b34  = {{2{mcand[WIDTH-1]}}, mcand};
                  sub4 = 1'b1;
               end
               default: b34 = '0;
            endcase
            as_b   = b34[WIDTH-1:0];
            as_sub = sub4;
`else
            as_b   = (mq[0] ^ q_1) ? mcand : '0;
            as_sub = mq[0] & ~q_1;
`endif
         end
         DIV: begin
            as_a   = {acc[WIDTH-2:0], mq[WIDTH-1]};
            as_b   = mcand;
            as_sub = 1'b1;
         end
         FIN: begin
            as_a   = '0;
            as_b   = mq;
            as_sub = 1'b1;
         end
         default: ;
      endcase
   end

   multdiv_addsub u_addsub (
      .a    (as_a),
      .b    (as_b),
      .sub  (as_sub),
      .sum  (as_sum),
      .cout (as_cout)
   );

   // The bit above the 32-bit sum is rebuilt from the carry so the arithmetic shift keeps the true sign.
   always_comb begin
      acc_nxt = acc;
      mq_nxt  = mq;
      q_1_nxt = q_1;
`ifdef MULTDIV_BOOTH4_EN
      hi = 2'b00;
`endif
      if (state == MULT) begin
`ifdef MULTDIV_BOOTH4_EN
         hi      = {acc[WIDTH-1], acc[WIDTH-1]}
                 + (sub4 ? ~b34[WIDTH+1:WIDTH] : b34[WIDTH+1:WIDTH])
                 + {1'b0, as_cout};
         acc_nxt = {hi, as_sum[WIDTH-1:2]};
         mq_nxt  = {as_sum[1:0], mq[WIDTH-1:2]};
         q_1_nxt = mq[1];
`else
         acc_nxt = {acc[WIDTH-1] ^ (as_sub ? ~as_b[WIDTH-1] : as_b[WIDTH-1]) ^ as_cout,
                    as_sum[WIDTH-1:1]};
         mq_nxt  = {as_sum[0], mq[WIDTH-1:1]};
         q_1_nxt = mq[0];
`endif
      end else if (state == DIV) begin
         acc_nxt = as_cout ? as_sum : as_a;
         mq_nxt  = {mq[WIDTH-2:0], as_cout};
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt            <= '0;
         acc            <= '0;
         mq             <= '0;
         mcand          <= '0;
         q_1            <= 1'b0;
         op_div         <= 1'b0;
         neg_res        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (accept) begin
         cnt      <= '0;
         acc      <= '0;
         q_1      <= 1'b0;
         op_div   <= ~ctrl_MULT;
         neg_res  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div_zero <= (data_operandB == '0);
         div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
         mcand    <= ctrl_MULT ? data_operandA : mag_b;
         mq       <= ctrl_MULT ? data_operandB : mag_a;
      end else if (state == MULT || state == DIV) begin
         acc <= acc_nxt;
         mq  <= mq_nxt;
         q_1 <= q_1_nxt;
         if (!cnt_last) cnt <= cnt + CNT_W'(1);
      end else if (state == FIN) begin
         if (!op_div) begin
            data_result    <= mq;
            data_exception <= (acc != {WIDTH{mq[WIDTH-1]}});
         end else if (div_zero) begin
            data_result    <= '0;
            data_exception <= 1'b1;
         end else begin
            data_result    <= neg_res ? as_sum : mq;
            data_exception <= div_ovf;
         end
      end
   end

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomized self-checking bench for multdiv_seq against an arithmetic reference model.
module tb_multdiv_seq;

   logic        clock;
   logic        reset;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int checks   = 0;
   int failures = 0;

`ifdef MULTDIV_BOOTH4_EN
   localparam int MLAT = 17;
`else
   localparam int MLAT = 33;
`endif

   multdiv_seq dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint p;
      int     sa;
      int     sb;
      int     lo;
      sa = a;
      sb = b;
      if (m) begin
         p  = longint'(sa) * longint'(sb);
         lo = int'(p[31:0]);
         r  = p[31:0];
         e  = (p != longint'(lo));
      end else if (sb == 0) begin
         r = 32'h0;
         e = 1'b1;
      end else if (sa == int'(32'h8000_0000) && sb == -1) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         r = sa / sb;
         e = 1'b0;
      end
   endfunction

   function automatic int exp_lat(input bit m, input logic [31:0] b);
      if (m) return MLAT;
      return (b == 32'h0) ? 2 : 33;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'h0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: v = $urandom_range(0, 20);
         4: v = -$urandom_range(1, 20);
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Leaves the bench at the falling edge just after the accepting edge.
   task automatic do_start(input bit sync, input bit m, input logic [31:0] a, input logic [31:0] b);
      if (sync) @(negedge clock);
      ctrl_MULT     = m;
      ctrl_DIV      = !m;
      data_operandA = a;
      data_operandB = b;
      @(negedge clock);
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_start: busy=%b, required 1", busy);
      end
   endtask

   task automatic wait_check(input bit m, input logic [31:0] a, input logic [31:0] b,
                             input string name, input int lat0, output int lat);
      logic [31:0] er;
      logic        ee;
      bit          seen;
      model(m, a, b, er, ee);
      lat  = lat0;
      seen = 0;
      while (!seen && lat < 100) begin
         @(negedge clock);
         lat++;
         if (data_resultRDY === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL %s_timeout: no resultRDY after %0d cycles", name, lat);
      end else begin
         checks++;
         if (lat !== exp_lat(m, b)) begin
            failures++;
            $display("FAIL %s_latency: got %0d, required %0d", name, lat, exp_lat(m, b));
         end
         checks++;
         if (data_result !== er) begin
            failures++;
            $display("FAIL %s_result: a=%h b=%h got %h, required %h", name, a, b, data_result, er);
         end
         checks++;
         if (data_exception !== ee) begin
            failures++;
            $display("FAIL %s_exception: a=%h b=%h got %b, required %b", name, a, b, data_exception, ee);
         end
         checks++;
         if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy_in_rdy: got %b, required 0", name, busy);
         end
      end
   endtask

   task automatic run_op(input bit m, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [31:0] er;
      logic        ee;
      int          lat;
      model(m, a, b, er, ee);
      do_start(1, m, a, b);
      wait_check(m, a, b, name, 0, lat);
      @(negedge clock);
      checks++;
      if (data_resultRDY !== 1'b0 || data_result !== er) begin
         failures++;
         $display("FAIL %s_hold: rdy=%b result=%h, required rdy=0 result=%h", name, data_resultRDY, data_result, er);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: result=%h exc=%b rdy=%b busy=%b, required all 0",
                  data_result, data_exception, data_resultRDY, busy);
      end
      reset = 1'b0;
   endtask

   task automatic test_mult();
      run_op(1, 32'd7, -32'sd3, "mult_7x-3");
      run_op(1, 32'h0001_0000, 32'h0001_0000, "mult_ovf");
      run_op(1, 32'h8000_0000, 32'd1, "mult_intmin");
      run_op(1, 32'h8000_0000, 32'h8000_0000, "mult_intmin_sq");
   endtask

   task automatic test_div();
      run_op(0, -32'sd7, 32'd2, "div_-7/2");
      run_op(0, 32'd100, -32'sd7, "div_100/-7");
      run_op(0, 32'd5, 32'd0, "div_zero");
      run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(0, 32'h8000_0000, 32'd3, "div_intmin/3");
   endtask

   task automatic test_reset_abort();
      int lat;
      do_start(1, 0, 32'd1000, 32'd7);
      repeat (9) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL abort_outputs: result=%h exc=%b rdy=%b busy=%b, required all 0",
                  data_result, data_exception, data_resultRDY, busy);
      end
      reset = 1'b0;
      do_start(0, 1, 32'd3, 32'd4);
      wait_check(1, 32'd3, 32'd4, "abort_then_mult", 0, lat);
   endtask

   task automatic test_busy_ignore();
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      a = $urandom;
      b = $urandom;
      do_start(1, 1, a, b);
      repeat (4) @(negedge clock);
      ctrl_DIV      = 1'b1;
      data_operandA = 32'd9;
      data_operandB = 32'd3;
      @(negedge clock);
      ctrl_DIV = 1'b0;
      wait_check(1, a, b, "busy_ignore", 5, lat);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      a = pick();
      b = pick();
      do_start(1, 1, a, b);
      wait_check(1, a, b, "b2b_first", 0, lat);
      do_start(0, 0, 32'd9, 32'd3);
      wait_check(0, 32'd9, 32'd3, "b2b_div", 0, lat);
      checks++;
      if (lat + 1 !== 34) begin
         failures++;
         $display("FAIL b2b_rdy_gap: got %0d cycles, required 34", lat + 1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         run_op(1'($urandom_range(0, 1)), pick(), pick(), "random");
      end
   endtask

   initial begin
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = 32'h0;
      data_operandB = 32'h0;
      test_reset();
      test_mult();
      test_div();
      test_reset_abort();
      test_busy_ignore();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
